alu_operand_stage: RTL

Registered successor of the ALU operand-select path. It selects ALU operands A/B from register-file, PC, immediate and constant sources. It resolves RAW hazards by forwarding from NFWD later pipeline stages. It holds results in a valid/ready pipeline register between decode and execute, and stalls decode when a matching producer's data is still pending (e.g. load in flight).

---
 rtl/alu_operand_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects A/B, forwards from later stages, and registers operands behind a valid/ready handshake.
// Optional feature macro: ALU_OPSTAGE_PERF_EN adds saturating hazard-cycle and issue counters.
module alu_operand_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NFWD = 2,
    parameter int unsigned REGW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REGW-1:0]      rs1_idx,
    input  logic [REGW-1:0]      rs2_idx,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      pc,
    input  logic [1:0]           asel,
    input  logic [1:0]           bsel,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD-1:0]      fwd_pending,
    input  logic [NFWD*REGW-1:0] fwd_rd,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [XLEN-1:0]      out_rs2
`ifdef ALU_OPSTAGE_PERF_EN
    ,
    output logic [31:0]          perf_hazard_cycles,
    output logic [31:0]          perf_issued
`endif
);

    localparam int unsigned PERFW = 32;
    localparam logic [XLEN-1:0] CONST4 = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] rs2;
    } opnd_t;

    opnd_t           out_q;
    opnd_t           nxt;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            hit1;
    logic            hit2;
    logic            pend1;
    logic            pend2;
    logic            hazard;
    logic            accept;

    // Youngest matching source wins; register 0 is never forwarded.
    always_comb begin
        rs1_fwd = rs1_data;
        rs2_fwd = rs2_data;
        hit1    = 1'b0;
        hit2    = 1'b0;
        pend1   = 1'b0;
        pend2   = 1'b0;
        for (int i = 0; i < int'(NFWD); i++) begin
            if (!hit1 && fwd_valid[i] && (fwd_rd[i*REGW +: REGW] != '0)
                && (fwd_rd[i*REGW +: REGW] == rs1_idx)) begin
                hit1    = 1'b1;
                rs1_fwd = fwd_data[i*XLEN +: XLEN];
                pend1   = fwd_pending[i];
            end
            if (!hit2 && fwd_valid[i] && (fwd_rd[i*REGW +: REGW] != '0)
                && (fwd_rd[i*REGW +: REGW] == rs2_idx)) begin
                hit2    = 1'b1;
                rs2_fwd = fwd_data[i*XLEN +: XLEN];
                pend2   = fwd_pending[i];
            end
        end
    end

    // rs2 hazards stall regardless of bsel since store data always needs it.
    always_comb begin
        hazard   = in_valid && (pend1 || pend2);
        in_ready = !hazard && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        nxt     = '0;
        nxt.rs2 = rs2_fwd;
        case (asel)
            2'b00:   nxt.a = rs1_fwd;
            2'b01:   nxt.a = pc;
            default: nxt.a = '0;
        endcase
        case (bsel)
            2'b00:   nxt.b = rs2_fwd;
            2'b01:   nxt.b = imm;
            2'b10:   nxt.b = CONST4;
            default: nxt.b = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_q     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_q     <= nxt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_a   = out_q.a;
    assign out_b   = out_q.b;
    assign out_rs2 = out_q.rs2;

`ifdef ALU_OPSTAGE_PERF_EN
    logic [PERFW-1:0] hz_cnt;
    logic [PERFW-1:0] iss_cnt;

    // Saturating counters hold at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hz_cnt  <= '0;
            iss_cnt <= '0;
        end else begin
            if (hazard && (hz_cnt != '1)) hz_cnt <= hz_cnt + PERFW'(1);
            if (accept && (iss_cnt != '1)) iss_cnt <= iss_cnt + PERFW'(1);
        end
    end

    assign perf_hazard_cycles = hz_cnt;
    assign perf_issued        = iss_cnt;
`endif

endmodule
